// File: rtl/bin_to_lcd_digits_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_lcd_digits_pkg
//  Description : Shared constants for the binary-to-ASCII-decimal converter:
//                FSM state encoding, ASCII code points and default sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package bin_to_lcd_digits_pkg;

    // FSM state encoding (2-bit, explicit)
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] EMIT    = 2'd2;

    // ASCII code points used for the digit stream
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Default sizing: 16-bit input needs 5 decimal digits (10^5 > 2^16)
    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_DIGITS = 5;

endpackage : bin_to_lcd_digits_pkg
`default_nettype wire

// File: rtl/bin_to_lcd_digits_bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Combinational double-dabble nibble correction. A BCD digit
//                of 5 or more gets +3 so that the following left shift
//                carries correctly into the next decimal digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3 (
    input  logic [3:0] nibble,
    output logic [3:0] corrected
);

    // Inputs above 9 never occur in a valid BCD register, so no wrap handling
    assign corrected = (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bin_to_lcd_digits.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_lcd_digits
//  Description : Captures a binary value on load, converts it to DIGITS BCD
//                digits with a bit-serial shift-add-3 loop (one bit per
//                cycle), then streams the digits MSD first as ASCII over a
//                valid/ready handshake. char_last marks the final digit.
//                Optional build macro LEADING_BLANK_EN: leading zero digits
//                are sent as spaces; the least significant digit is always
//                a numeral.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_lcd_digits
    import bin_to_lcd_digits_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value_in,
    input  logic             load,
    output logic             busy,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             char_last
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_bin;
    logic [c_BCD_W-1:0] r_bcd;
    logic [c_BCD_W-1:0] w_bcd_adj;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [3:0]         w_nibble;
    logic [7:0]         w_char;
    logic               w_xfer;
    logic               w_last_xfer;

    assign w_xfer      = char_valid && char_ready;
    assign w_last_xfer = w_xfer && (r_idx == '0);

    // One add-3 corrector per BCD digit, applied before every shift
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .nibble    (r_bcd[4*gi +: 4]),
                .corrected (w_bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic; conversion ends on the cycle the counter hits zero
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (load)                    w_next_state = CONVERT;
            CONVERT: if (r_bit_cnt == c_CNT_ONE)  w_next_state = EMIT;
            EMIT:    if (w_last_xfer)             w_next_state = IDLE;
            default:                              w_next_state = IDLE;
        endcase
    end

    // Datapath: capture, shift-add-3 conversion, digit index walk
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_bin     <= value_in;
                        r_bcd     <= '0;
                        r_bit_cnt <= c_CNT_INIT;
                    end
                end
                CONVERT: begin
                    // Top nibble cannot overflow given 10^DIGITS > 2^WIDTH
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_bit_cnt      <= r_bit_cnt - c_CNT_ONE;
                    if (r_bit_cnt == c_CNT_ONE) r_idx <= c_IDX_LAST;
                end
                EMIT: begin
                    if (w_xfer && (r_idx != '0)) r_idx <= r_idx - c_IDX_ONE;
                end
                default: ;
            endcase
        end
    end

    // Select the digit currently being presented
    always_comb begin
        w_nibble = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_idx == c_IDX_W'(d)) w_nibble = r_bcd[4*d +: 4];
        end
    end

`ifdef LEADING_BLANK_EN
    logic r_lead;

    // Tracks "only zeros sent so far"; cleared by the first nonzero digit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               r_lead <= 1'b0;
        else if (r_state == CONVERT)              r_lead <= 1'b1;
        else if (w_xfer && (w_nibble != 4'd0))    r_lead <= 1'b0;
    end

    assign w_char = (r_lead && (w_nibble == 4'd0) && (r_idx != '0))
                    ? ASCII_SPACE : (ASCII_ZERO + {4'd0, w_nibble});
`else
    assign w_char = ASCII_ZERO + {4'd0, w_nibble};
`endif

    // Outputs decoded from state so an async reset clears them at once
    always_comb begin
        busy       = 1'b0;
        char_valid = 1'b0;
        char_last  = 1'b0;
        char_out   = 8'h00;
        case (r_state)
            CONVERT: busy = 1'b1;
            EMIT: begin
                busy       = 1'b1;
                char_valid = 1'b1;
                char_last  = (r_idx == '0);
                char_out   = w_char;
            end
            default: ;
        endcase
    end

endmodule : bin_to_lcd_digits
`default_nettype wire

// File: tb/tb_bin_to_lcd_digits.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_lcd_digits
//  Description : Directed self-checking bench for bin_to_lcd_digits. Checks
//                reset values, latency, digit strings, backpressure hold,
//                ignored loads, async reset abort and back-to-back use.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_lcd_digits;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        load       = 1'b0;
    logic        char_ready = 1'b1;
    logic [15:0] value_in   = '0;
    logic        busy;
    logic        char_valid;
    logic        char_last;
    logic [7:0]  char_out;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LEADING_BLANK_EN
    localparam logic [39:0] EXP_ZERO  = "    0";
    localparam logic [39:0] EXP_6699  = " 6699";
    localparam logic [39:0] EXP_100   = "  100";
    localparam logic [39:0] EXP_SEVEN = "    7";
`else
    localparam logic [39:0] EXP_ZERO  = "00000";
    localparam logic [39:0] EXP_6699  = "06699";
    localparam logic [39:0] EXP_100   = "00100";
    localparam logic [39:0] EXP_SEVEN = "00007";
`endif

    always #5 clk = ~clk;

    bin_to_lcd_digits #(.WIDTH(16), .DIGITS(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .load       (load),
        .busy       (busy),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .char_last  (char_last)
    );

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1
    task automatic start(input string tag, input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        value_in = 16'hBEEF;
        check({tag, "_busy"}, 40'(busy), 40'd1);
    endtask

    // Waits for the first valid character, starting in cycle 'cyc0'
    task automatic wait_first(input string tag, input int cyc0);
        int cyc = cyc0;
        while (!char_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 40'(cyc), 40'd17);
    endtask

    // Drains the five characters using a repeating ready pattern
    task automatic collect(input string tag, input logic [3:0] pat,
                           input logic [39:0] exp, input bit load_on_last);
        logic [39:0] got       = '0;
        logic [4:0]  lasts     = '0;
        logic [7:0]  held      = '0;
        logic        held_last = 1'b0;
        bit          stalled   = 1'b0;
        int          n = 0, k = 0, guard = 0;
        while (n < 5 && guard < 60) begin
            if (stalled) begin
                check({tag, "_hold"}, 40'(char_out), 40'(held));
                check({tag, "_holdlast"}, 40'(char_last), 40'(held_last));
            end
            char_ready = pat[k % 4];
            k++;
            if (char_valid && char_ready) begin
                got     = {got[31:0], char_out};
                lasts   = {lasts[3:0], char_last};
                n++;
                stalled = 1'b0;
                if (n == 5 && load_on_last) begin
                    value_in = 16'h0001;
                    load     = 1'b1;
                end
            end else begin
                stalled   = char_valid;
                held      = char_out;
                held_last = char_last;
            end
            @(negedge clk);
            guard++;
        end
        load       = 1'b0;
        char_ready = 1'b1;
        if (n < 5) check({tag, "_timeout"}, 40'(n), 40'd5);
        check(tag, got, exp);
        check({tag, "_last"}, 40'(lasts), 40'b00001);
        check({tag, "_busyfall"}, 40'(busy), 40'd0);
        check({tag, "_validfall"}, 40'(char_valid), 40'd0);
    endtask

    initial begin
        // Reset values
        #1;
        check("rst_busy",  40'(busy),       40'd0);
        check("rst_valid", 40'(char_valid), 40'd0);
        check("rst_last",  40'(char_last),  40'd0);
        check("rst_char",  40'(char_out),   40'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Zero value, ready always high
        start("zero", 16'h0000);
        wait_first("zero", 1);
        collect("zero", 4'b1111, EXP_ZERO, 1'b0);

        // Maximum value
        start("max", 16'hFFFF);
        wait_first("max", 1);
        collect("max", 4'b1111, "65535", 1'b0);

        // Fibonacci 28657 with ready pattern 1,0,0,1
        start("fib", 16'h6FF1);
        wait_first("fib", 1);
        collect("fib", 4'b1001, "28657", 1'b0);

        // Loads during CONVERT, EMIT and on the final transfer are ignored
        start("ign", 16'h1A2B);
        repeat (4) @(negedge clk);
        value_in = 16'h0001;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        wait_first("ign", 6);
        value_in   = 16'h0001;
        load       = 1'b1;
        char_ready = 1'b0;
        @(negedge clk);
        load = 1'b0;
        collect("ign", 4'b1111, EXP_6699, 1'b1);

        // Async reset during CONVERT
        start("rstc", 16'h0064);
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rstc_busy",  40'(busy),       40'd0);
        check("rstc_valid", 40'(char_valid), 40'd0);
        check("rstc_char",  40'(char_out),   40'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Async reset during EMIT
        start("rste", 16'h0064);
        wait_first("rste", 1);
        #2 reset = 1'b0;
        #1;
        check("rste_busy",  40'(busy),       40'd0);
        check("rste_valid", 40'(char_valid), 40'd0);
        check("rste_char",  40'(char_out),   40'd0);
        check("rste_last",  40'(char_last),  40'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rste_after", 40'(char_valid), 40'd0);

        // Recovery after reset
        start("hund", 16'h0064);
        wait_first("hund", 1);
        collect("hund", 4'b1111, EXP_100, 1'b0);

        // Back-to-back: reload in the idle cycle after the last character
        start("b2b1", 16'd12345);
        wait_first("b2b1", 1);
        collect("b2b1", 4'b1111, "12345", 1'b0);
        start("b2b2", 16'd7);
        wait_first("b2b2", 1);
        collect("b2b2", 4'b1111, EXP_SEVEN, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bin_to_lcd_digits
`default_nettype wire

// File: doc/bin_to_lcd_digits.md
Name: bin_to_lcd_digits

Overview:
- Sits between the register file's B read bus and the LCD controller.
- Captures a 16-bit register value on a load strobe and converts it to 5 decimal digits with sequential shift-add-3 (double-dabble).
- Streams the digits as ASCII characters, most significant first, over a valid/ready handshake into the LCD character writer.
- Lets the board display Fibonacci results in decimal instead of raw binary.

Parameters:
- WIDTH, 16: bit width of the captured binary value.
- DIGITS, 5: number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- value_in  input  WIDTH  binary value to convert, sampled on an accepted load.
- load  input  1  start request; accepted only in IDLE.
- busy  output  1  high from the cycle after an accepted load until the last character is accepted.
- char_out  output  8  ASCII character.
- char_valid  output  1  char_out holds a valid character.
- char_ready  input  1  consumer accepts char_out this cycle.
- char_last  output  1  qualifies the final (least significant) digit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy=0, char_valid=0, char_last=0, char_out=8'h00.
  - Shift register, BCD register and counters all cleared.
- IDLE:
  - load=1 latches value_in into the binary shift register and clears the BCD register.
  - Bit counter := WIDTH; next state CONVERT; busy=1 from the next cycle.
- CONVERT, one bit per cycle, exactly WIDTH cycles:
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1 and the counter decrements.
  - When the counter reaches 0, go to EMIT with digit index := DIGITS-1.
- EMIT:
  - char_valid=1; char_out = 8'h30 + nibble[index].
  - char_last=1 when index==0.
  - A transfer occurs when char_valid && char_ready.
  - On transfer with index>0: decrement index.
  - On transfer with index==0: go to IDLE; char_valid, busy and char_last drop the following cycle.
- Latency: load accepted at cycle 0 -> first char_valid at cycle WIDTH+1 (17 for the defaults). With char_ready tied high, the last character transfers at cycle WIDTH+DIGITS.
- Backpressure: while char_valid && !char_ready, char_out, char_last and the index hold stable. There is no timeout.
- load while busy: ignored; value_in is not sampled and the conversion in progress is not disturbed.
- load in the same cycle as the final transfer: ignored; state is still EMIT in that cycle.
- Width rule: the BCD register is 4*DIGITS bits. An overflow of the top nibble is impossible under the DIGITS constraint, so no saturation is performed.
- Reset asserted mid-CONVERT or mid-EMIT: immediate abort to reset values; no partial character is emitted afterwards.

Optional Feature:
- Macro: LEADING_BLANK_EN.
- Defined: leading zero digits are emitted as 8'h20 (space). The least significant digit is always a numeral, so 0 displays as "    0". Character count is unchanged (always DIGITS).
- Undefined: all digits are numerals, zero-padded ("00000").

Decomposition:
- Shared package contents:
  - State encoding localparams: IDLE=2'd0, CONVERT=2'd1, EMIT=2'd2.
  - ASCII_ZERO=8'h30, ASCII_SPACE=8'h20.
  - Default WIDTH/DIGITS constants.
- Sub-module: bcd_add3, a combinational 4-bit nibble correction (in >= 5 ? in+3 : in), instantiated DIGITS times inside a generate loop.
- FSM, counters and handshake stay in the parent.

Test Plan:
- load value_in=16'h0000, char_ready=1 -> chars 30 30 30 30 30; first valid at cycle 17; char_last only on the 5th. With LEADING_BLANK_EN: 20 20 20 20 30.
- load 16'hFFFF -> "65535" (36 35 35 33 35); busy falls the cycle after char_last transfers.
- load 16'h6FF1 (Fib 28657) with char_ready toggling 1,0,0,1 -> "28657"; char_out stable through every stall; no duplicated or dropped digits.
- load 16'h1A2B, then pulse load with 16'h0001 during CONVERT and during EMIT -> output stays "06699"; second value never appears.
- load 16'h0064, assert reset=0 at cycle 8 for one cycle -> busy, char_valid and char_out are 0 immediately and asynchronously. A subsequent load 16'h0064 yields "00100".
- Back-to-back: load 16'd12345, drain, load in the idle cycle after char_last -> "12345", then the second result follows with the same 17-cycle latency.
